// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 16-bit words over req/ack,
// and hands one instruction at a time to decode over valid/ready.
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic        ir_valid,
  input  logic        ir_ready,
  output logic [15:0] ir,
  output logic [15:0] ir_pc,
  output logic [3:0]  ir_opcode,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_target,
  output logic [15:0] fetch_count
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] pc;

  // imem_addr is registered and only reloaded on entry to S_REQ, so in
  // S_DRAIN it still carries the stale address of the outstanding request.
  // NOTE: all state here updates with non-blocking assignments so every
  // branch reads the pre-edge values of pc, state and the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      imem_req    <= 1'b1;
      imem_addr   <= RESET_PC;
      ir_valid    <= 1'b0;
      ir          <= '0;
      ir_pc       <= '0;
      fetch_count <= '0;
    end else begin
      case (state)
        S_REQ: begin
          if (redirect_valid) begin
            pc <= redirect_target;
            if (imem_ack) begin
              imem_addr <= redirect_target;
            end else begin
              // Request cannot be withdrawn; wait out its ack in S_DRAIN.
              state <= S_DRAIN;
            end
          end else if (imem_ack) begin
            ir       <= imem_rdata;
            ir_pc    <= pc;
            pc       <= pc + PC_STEP;
            imem_req <= 1'b0;
            ir_valid <= 1'b1;
            state    <= S_HOLD;
          end
        end

        S_DRAIN: begin
          if (redirect_valid) begin
            pc <= redirect_target;
          end
          if (imem_ack) begin
            imem_addr <= redirect_valid ? redirect_target : pc;
            state     <= S_REQ;
          end
        end

        S_HOLD: begin
          if (redirect_valid) begin
            pc        <= redirect_target;
            imem_req  <= 1'b1;
            imem_addr <= redirect_target;
            ir_valid  <= 1'b0;
            state     <= S_REQ;
          end else if (ir_ready) begin
            fetch_count <= fetch_count + 16'd1;
            imem_req    <= 1'b1;
            imem_addr   <= pc;
            ir_valid    <= 1'b0;
            state       <= S_REQ;
          end
        end

        default: begin
          imem_req  <= 1'b1;
          imem_addr <= pc;
          ir_valid  <= 1'b0;
          state     <= S_REQ;
        end
      endcase
    end
  end

  assign ir_opcode = ir[15:12];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (RESET_PC = 16'h0010).
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir;
  logic [15:0] ir_pc;
  logic [3:0]  ir_opcode;
  logic        redirect_valid;
  logic [15:0] redirect_target;
  logic [15:0] fetch_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_unit #(
    .RESET_PC(16'h0010),
    .PC_STEP (16'd1)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir             (ir),
    .ir_pc          (ir_pc),
    .ir_opcode      (ir_opcode),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [15:0] exp_pc;

    rst             = 1'b1;
    imem_ack        = 1'b0;
    imem_rdata      = 16'h0000;
    ir_ready        = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 16'h0000;

    // Reset state
    step();
    check("rst_req",   {15'd0, imem_req}, 16'd1);
    check("rst_addr",  imem_addr,         16'h0010);
    check("rst_valid", {15'd0, ir_valid}, 16'd0);
    check("rst_ir",    ir,                16'h0000);
    check("rst_ir_pc", ir_pc,             16'h0000);
    check("rst_count", fetch_count,       16'h0000);
    rst      = 1'b0;
    ir_ready = 1'b1;

    // Zero-wait memory, decode always ready: three back-to-back fetches
    for (int i = 0; i < 3; i++) begin
      exp_pc = 16'h0010 + 16'(i);
      check("seq_addr", imem_addr, exp_pc);
      imem_ack   = 1'b1;
      imem_rdata = {exp_pc[3:0], 12'h000};
      step();
      imem_ack   = 1'b0;
      check("seq_valid", {15'd0, ir_valid}, 16'd1);
      check("seq_ir",    ir,    {exp_pc[3:0], 12'h000});
      check("seq_ir_pc", ir_pc, exp_pc);
      step();
      check("seq_count", fetch_count, 16'(i + 1));
    end
    check("seq_count_final", fetch_count, 16'd3);
    ir_ready = 1'b0;

    // Slow memory (ack on third cycle), decode stalls five cycles
    for (int k = 0; k < 3; k++) begin
      check("slow_req",  {15'd0, imem_req}, 16'd1);
      check("slow_addr", imem_addr, 16'h0013);
      imem_ack   = (k == 2);
      imem_rdata = (k == 2) ? 16'h2A4C : 16'hDEAD;
      step();
    end
    imem_ack = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", {15'd0, ir_valid}, 16'd1);
      check("stall_ir",    ir,    16'h2A4C);
      check("stall_ir_pc", ir_pc, 16'h0013);
      check("stall_noreq", {15'd0, imem_req}, 16'd0);
      step();
    end
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("stall_count",  fetch_count, 16'd4);
    check("stall_req",    {15'd0, imem_req}, 16'd1);
    check("stall_next",   imem_addr, 16'h0014);

    // Redirect in S_REQ with no ack: drain the stale request first
    redirect_valid  = 1'b1;
    redirect_target = 16'h0040;
    step();
    redirect_valid = 1'b0;
    check("drain_addr0", imem_addr, 16'h0014);
    check("drain_req0",  {15'd0, imem_req}, 16'd1);
    check("drain_vld0",  {15'd0, ir_valid}, 16'd0);
    step();
    check("drain_addr1", imem_addr, 16'h0014);
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    imem_ack = 1'b0;
    check("drain_new_addr", imem_addr, 16'h0040);
    check("drain_vld2",     {15'd0, ir_valid}, 16'd0);
    check("drain_ir_kept",  ir, 16'h2A4C);
    imem_ack   = 1'b1;
    imem_rdata = 16'h4123;
    step();
    imem_ack = 1'b0;
    check("tgt_ir",    ir,    16'h4123);
    check("tgt_ir_pc", ir_pc, 16'h0040);

    // Redirect in S_HOLD beats ir_ready in the same cycle
    redirect_valid  = 1'b1;
    redirect_target = 16'h0080;
    ir_ready        = 1'b1;
    step();
    redirect_valid = 1'b0;
    ir_ready       = 1'b0;
    check("hold_redir_count", fetch_count, 16'd4);
    check("hold_redir_valid", {15'd0, ir_valid}, 16'd0);
    check("hold_redir_addr",  imem_addr, 16'h0080);

    // Redirect with coincident ack in S_REQ: data discarded, PC to 16'hFFFF
    redirect_valid  = 1'b1;
    redirect_target = 16'hFFFF;
    imem_ack        = 1'b1;
    imem_rdata      = 16'h9999;
    step();
    redirect_valid = 1'b0;
    check("ack_redir_addr",  imem_addr, 16'hFFFF);
    check("ack_redir_valid", {15'd0, ir_valid}, 16'd0);
    check("ack_redir_ir",    ir, 16'h4123);
    imem_rdata = 16'h6000;
    step();
    imem_ack = 1'b0;
    check("wrap_opcode", {12'd0, ir_opcode}, 16'h0006);
    check("wrap_ir_pc",  ir_pc, 16'hFFFF);
    ir_ready = 1'b1;
    step();
    ir_ready = 1'b0;
    check("wrap_count", fetch_count, 16'd5);
    check("wrap_addr",  imem_addr, 16'h0000);

    // Reset in S_DRAIN with ack in the same cycle
    redirect_valid  = 1'b1;
    redirect_target = 16'h1234;
    step();
    redirect_valid = 1'b0;
    check("pre_rst_drain_addr", imem_addr, 16'h0000);
    rst        = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 16'hFFFF;
    step();
    rst = 1'b0;
    check("rst_drain_req",   {15'd0, imem_req}, 16'd1);
    check("rst_drain_addr",  imem_addr, 16'h0010);
    check("rst_drain_valid", {15'd0, ir_valid}, 16'd0);
    check("rst_drain_count", fetch_count, 16'd0);
    check("rst_drain_ir",    ir, 16'h0000);
    // Ack still pending after reset counts for the RESET_PC request
    imem_rdata = 16'h0A0A;
    step();
    imem_ack = 1'b0;
    check("post_rst_ir",    ir,    16'h0A0A);
    check("post_rst_ir_pc", ir_pc, 16'h0010);
    check("post_rst_valid", {15'd0, ir_valid}, 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
